ws_array_feeder: RTL and testbench

Upstream feeder for the weight-stationary systolic array; drives the top edge (in_weight, weight_we) and left edge (in_act) of the PE grid. Buffers one ROWS x COLS weight tile, shifts it down the array with weight_we held so every PE latches its stationary value, then streams activation vectors with per-row skew (row r delayed r cycles). Sequencing runs from a start pulse and ends with a done pulse; psum collection is downstream.

---
 rtl/ws_array_feeder.sv | 176 +++++++++++++++++
 tb/tb_ws_array_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_array_feeder.sv
// rtl/ws_array_feeder.sv - weight-stationary array feeder
// Buffers a weight tile, shifts it into the PE grid, then streams skewed activation vectors.
module ws_array_feeder #(
  parameter int D_W   = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vec,
  output logic                 busy,
  output logic                 done,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [COLS*D_W-1:0]  w_data,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ROWS*D_W-1:0]  a_data,
  output logic                 weight_we,
  output logic [COLS*D_W-1:0]  top_weight,
  output logic [ROWS*D_W-1:0]  left_act,
  output logic [ROWS-1:0]      act_valid
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WFILL  = 3'd1;
  localparam logic [2:0] S_WLOAD  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // A single-row array has no skew to flush, so it skips DRAIN entirely.
  localparam logic [2:0]       S_FLUSH    = (ROWS > 1) ? S_DRAIN : S_DONE;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] DRAIN_LAST = IDX_W'((ROWS > 1) ? ROWS - 2 : 0);

  logic [2:0]          state_q, state_d;
  logic [IDX_W-1:0]    fill_q, fill_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    nv_q, nv_d;
  logic [COLS*D_W-1:0] tile_q [0:ROWS-1];
  logic [COLS*D_W-1:0] tile_d [0:ROWS-1];
  logic                busy_q, busy_d, done_q, done_d;
  logic                w_ready_q, w_ready_d, a_ready_q, a_ready_d;
  logic                we_q, we_d;
  logic [COLS*D_W-1:0] top_q, top_d;
  logic                w_hs, a_hs;

  assign w_hs = w_valid && w_ready_q;
  assign a_hs = a_valid && a_ready_q;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    tile_d  = tile_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d    = num_vec;
          cnt_d   = '0;
          fill_d  = '0;
          idx_d   = '0;
          state_d = S_WFILL;
        end
      end
      S_WFILL: begin
        if (w_hs) begin
          tile_d[fill_q] = w_data;
          if (fill_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_WLOAD;
          end else begin
            fill_d = fill_q + IDX_W'(1);
          end
        end
      end
      S_WLOAD: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = (nv_q == '0) ? S_FLUSH : S_STREAM;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_STREAM: begin
        if (a_hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == nv_q) state_d = S_FLUSH;
        end
      end
      S_DRAIN: begin
        if (idx_q == DRAIN_LAST) state_d = S_DONE;
        else idx_d = idx_q + IDX_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    w_ready_d = (state_d == S_WFILL);
    a_ready_d = (state_d == S_STREAM) && (cnt_d < nv_d);
    we_d      = (state_d == S_WLOAD);
    top_d     = we_d ? tile_d[LAST_IDX - idx_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fill_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      nv_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      we_q      <= 1'b0;
      top_q     <= '0;
      for (int k = 0; k < ROWS; k++) tile_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      nv_q      <= nv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      we_q      <= we_d;
      top_q     <= top_d;
      tile_q    <= tile_d;
    end
  end

  // Row r carries r+1 register stages; non-handshake cycles push zero bubbles.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [D_W-1:0] pipe_q [0:r];
    logic [r:0]     vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) pipe_q[k] <= '0;
        vld_q <= '0;
      end else begin
        pipe_q[0] <= a_hs ? a_data[r*D_W +: D_W] : '0;
        vld_q[0]  <= a_hs;
        for (int k = 1; k <= r; k++) begin
          pipe_q[k] <= pipe_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
      end
    end

    assign left_act[r*D_W +: D_W] = pipe_q[r];
    assign act_valid[r]           = vld_q[r];
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign w_ready    = w_ready_q;
  assign a_ready    = a_ready_q;
  assign weight_we  = we_q;
  assign top_weight = top_q;

endmodule

// File: tb/tb_ws_array_feeder.sv
// tb/tb_ws_array_feeder.sv - self-checking bench for ws_array_feeder
module tb_ws_array_feeder;
  localparam int D_W = 8, ROWS = 4, COLS = 4, CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [CNT_W-1:0]    num_vec = '0;
  logic                busy, done;
  logic                w_valid = 1'b0;
  logic                w_ready;
  logic [COLS*D_W-1:0] w_data = '0;
  logic                a_valid = 1'b0;
  logic                a_ready;
  logic [ROWS*D_W-1:0] a_data = '0;
  logic                weight_we;
  logic [COLS*D_W-1:0] top_weight;
  logic [ROWS*D_W-1:0] left_act;
  logic [ROWS-1:0]     act_valid;

  ws_array_feeder #(.D_W(D_W), .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .weight_we(weight_we), .top_weight(top_weight), .left_act(left_act), .act_valid(act_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int cyc; } exp_t;
  typedef struct { int nv; int gap; int base; bit noise; int exp_valid; } job_t;

  int   checks = 0, failures = 0;
  int   cyc = 0;
  exp_t sbq [ROWS][$];
  int   valid_cnt [ROWS];
  int   done_cnt = 0;
  int   we_run = 0, last_we_run = 0, fall_cyc = 0;
  int   pe [ROWS][COLS];
  int   exp_tile [ROWS][COLS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cyc %0d)", name, cyc);
  endtask

  // Scoreboard monitor plus a reference model of the PE weight shift chain.
  always @(negedge clk) begin
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      if (act_valid[r]) begin
        valid_cnt[r]++;
        if (sbq[r].size() == 0) fail_now($sformatf("unexpected_act_valid row%0d", r));
        else begin
          e = sbq[r].pop_front();
          chk($sformatf("left_act row%0d", r), left_act[r*D_W +: D_W], e.val);
          chk($sformatf("act_cycle row%0d", r), cyc, e.cyc);
        end
      end else begin
        chk($sformatf("bubble_zero row%0d", r), left_act[r*D_W +: D_W], 0);
      end
    end
    if (weight_we) begin
      if (we_run >= ROWS) fail_now("weight_we_too_long");
      else for (int c = 0; c < COLS; c++)
        chk($sformatf("top_weight i%0d c%0d", we_run, c), top_weight[c*D_W +: D_W],
            exp_tile[ROWS-1-we_run][c]);
      for (int c = 0; c < COLS; c++) begin
        for (int r = ROWS - 1; r > 0; r--) pe[r][c] = pe[r-1][c];
        pe[0][c] = int'(top_weight[c*D_W +: D_W]);
      end
      we_run++;
    end else if (we_run > 0) begin
      last_we_run = we_run;
      fall_cyc    = cyc;
      we_run      = 0;
      chk("top_weight_after_load", top_weight, 0);
    end
    if (done) done_cnt++;
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_w_ready"}, w_ready, 0);
    chk({tag, "_a_ready"}, a_ready, 0);
    chk({tag, "_weight_we"}, weight_we, 0);
    chk({tag, "_act_valid"}, act_valid, 0);
    chk({tag, "_top_weight"}, top_weight, 0);
    chk({tag, "_left_act"}, left_act, 0);
  endtask

  task automatic start_and_fill(input job_t j);
    int k, to;
    bit hs;
    for (int r = 0; r < ROWS; r++) begin
      valid_cnt[r] = 0;
      for (int c = 0; c < COLS; c++) exp_tile[r][c] = j.base + 4*r + c;
    end
    last_we_run = 0;
    @(negedge clk);
    start = 1'b1;
    num_vec = CNT_W'(j.nv);
    @(negedge clk);
    start = 1'b0;
    num_vec = CNT_W'(j.nv + 7);
    chk("busy_after_start", busy, 1);
    k = 0;
    to = 0;
    while (k < ROWS && to < 100) begin
      if (j.noise && (to % 2 == 1)) begin
        w_valid = 1'b0;
        w_data  = '1;
        if (to == 1) start = 1'b1;
      end else begin
        w_valid = 1'b1;
        for (int c = 0; c < COLS; c++) w_data[c*D_W +: D_W] = D_W'(exp_tile[k][c]);
      end
      hs = w_valid && w_ready;
      @(negedge clk);
      start = 1'b0;
      if (hs) k++;
      to++;
    end
    w_valid = 1'b0;
    if (k < ROWS) fail_now("wfill_timeout");
  endtask

  task automatic run_job(input job_t j);
    int v, gap, to, tlast, d0, exp_done;
    bit hs;
    exp_t e;
    d0 = done_cnt;
    start_and_fill(j);
    if (j.noise) begin
      a_valid = 1'b1;
      a_data  = '1;
      repeat (2) @(negedge clk);
    end
    v = 0; gap = 0; to = 0; tlast = 0;
    while (v < j.nv && to < 500) begin
      if (gap > 0) begin
        a_valid = 1'b0;
        gap--;
        hs = 1'b0;
      end else begin
        a_valid = 1'b1;
        for (int r = 0; r < ROWS; r++) a_data[r*D_W +: D_W] = D_W'(j.base + 4*v + r + 1);
        hs = a_ready;
      end
      if (hs) begin
        for (int r = 0; r < ROWS; r++) begin
          e.val = j.base + 4*v + r + 1;
          e.cyc = cyc + 1 + r;
          sbq[r].push_back(e);
        end
        tlast = cyc + 1;
        v++;
        gap = j.gap;
      end
      @(negedge clk);
      to++;
    end
    if (v < j.nv) fail_now("stream_timeout");
    a_valid = 1'b1;
    a_data  = '1;
    to = 0;
    while (!done && to < 100) begin
      if (j.nv > 0) chk("a_ready_after_last", a_ready, 0);
      @(negedge clk);
      to++;
    end
    a_valid = 1'b0;
    if (!done) fail_now("done_timeout");
    else begin
      exp_done = (j.nv > 0) ? tlast + ROWS - 1 : fall_cyc + ROWS - 1;
      chk("done_cycle", cyc, exp_done);
      chk("busy_at_done", busy, 1);
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("weight_we_cycles", last_we_run, ROWS);
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("act_valid_count row%0d", r), valid_cnt[r], j.exp_valid);
      chk($sformatf("scoreboard_empty row%0d", r), sbq[r].size(), 0);
      for (int c = 0; c < COLS; c++)
        chk($sformatf("pe_weight r%0d c%0d", r, c), pe[r][c], exp_tile[r][c]);
    end
  endtask

  task automatic reset_mid_stream(input job_t j);
    int to, d0;
    exp_t e;
    start_and_fill(j);
    to = 0;
    while (!a_ready && to < 50) begin
      @(negedge clk);
      to++;
    end
    if (!a_ready) fail_now("reset_test_no_a_ready");
    a_valid = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      a_data[r*D_W +: D_W] = D_W'(j.base + r + 1);
      e.val = j.base + r + 1;
      e.cyc = cyc + 1 + r;
      sbq[r].push_back(e);
    end
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) sbq[r].delete();
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", done_cnt - d0, 0);
    chk("idle_after_abort", busy, 0);
  endtask

  job_t jobs [5];

  initial begin
    jobs[0] = '{nv: 3, gap: 0, base: 0,   noise: 1'b0, exp_valid: 3};
    jobs[1] = '{nv: 2, gap: 2, base: 16,  noise: 1'b0, exp_valid: 2};
    jobs[2] = '{nv: 0, gap: 0, base: 32,  noise: 1'b0, exp_valid: 0};
    jobs[3] = '{nv: 5, gap: 1, base: 48,  noise: 1'b1, exp_valid: 5};
    jobs[4] = '{nv: 1, gap: 0, base: 100, noise: 1'b0, exp_valid: 1};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 5; i++) run_job(jobs[i]);

    reset_mid_stream('{nv: 3, gap: 0, base: 150, noise: 1'b0, exp_valid: 1});
    run_job('{nv: 3, gap: 0, base: 200, noise: 1'b0, exp_valid: 3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
